// File: rtl/imm_encoder.sv
// Elastic two-stage immediate packer: scatters a 32-bit immediate into the
// I/S/B/J field positions of a base RV32I instruction, with range checking.
`timescale 1ns/1ps

module imm_encoder #(
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      immsrc,
  input  logic [31:0]     imm,
  input  logic [31:0]     base_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     instr_out,
  output logic            imm_err,
  output logic [ERRW-1:0] err_count
);

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  logic            r_s1_valid;
  logic [1:0]      r_s1_immsrc;
  logic [31:0]     r_s1_imm;
  logic [31:0]     r_s1_base;

  logic            r_s2_valid;
  logic [31:0]     r_s2_instr;
  logic            r_s2_err;

  logic [ERRW-1:0] r_err_count;

  logic            w_s2_advance;
  logic            w_s1_load;
  logic [31:0]     w_enc_instr;
  logic            w_enc_err;
  logic            w_out_fire;

  // Stage 2 can take a new beat whenever it is empty or is being drained.
  assign w_s2_advance = !r_s2_valid || out_ready;
  assign in_ready     = !r_s1_valid || w_s2_advance;
  assign w_s1_load    = in_valid && in_ready;
  assign w_out_fire   = r_s2_valid && out_ready;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_enc_instr = r_s1_base;
    w_enc_err   = 1'b0;
    case (r_s1_immsrc)
      IMM_I: begin
        w_enc_instr[31:20] = r_s1_imm[11:0];
        w_enc_err          = (r_s1_imm[31:11] != {21{r_s1_imm[11]}});
      end
      IMM_S: begin
        w_enc_instr[31:25] = r_s1_imm[11:5];
        w_enc_instr[11:7]  = r_s1_imm[4:0];
        w_enc_err          = (r_s1_imm[31:11] != {21{r_s1_imm[11]}});
      end
      IMM_B: begin
        w_enc_instr[31]    = r_s1_imm[12];
        w_enc_instr[30:25] = r_s1_imm[10:5];
        w_enc_instr[11:8]  = r_s1_imm[4:1];
        w_enc_instr[7]     = r_s1_imm[11];
        w_enc_err          = (r_s1_imm[31:12] != {20{r_s1_imm[12]}}) || r_s1_imm[0];
      end
      IMM_J: begin
        w_enc_instr[31]    = r_s1_imm[20];
        w_enc_instr[30:21] = r_s1_imm[10:1];
        w_enc_instr[20]    = r_s1_imm[11];
        w_enc_instr[19:12] = r_s1_imm[19:12];
        w_enc_err          = (r_s1_imm[31:20] != {12{r_s1_imm[20]}}) || r_s1_imm[0];
      end
      default: begin
        w_enc_instr = r_s1_base;
        w_enc_err   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      // NOTE: datapath registers are reset too; they are few and it keeps outputs deterministic after reset.
      r_s1_immsrc <= 2'b00;
      r_s1_imm    <= 32'd0;
      r_s1_base   <= 32'd0;
    end else begin
      if (in_ready) begin
        r_s1_valid <= in_valid;
      end
      if (w_s1_load) begin
        r_s1_immsrc <= immsrc;
        r_s1_imm    <= imm;
        r_s1_base   <= base_instr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_instr <= 32'd0;
      r_s2_err   <= 1'b0;
    end else if (w_s2_advance) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_instr <= w_enc_instr;
        r_s2_err   <= w_enc_err;
      end
    end
  end

  // Counts only beats actually taken downstream; sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= '0;
    end else if (w_out_fire && r_s2_err && !(&r_err_count)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

  assign out_valid = r_s2_valid;
  assign instr_out = r_s2_instr;
  assign imm_err   = r_s2_err;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors plus randomized beats
// against a field-table reference model; second instance checks saturation.
`timescale 1ns/1ps

module tb_imm_encoder;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  immsrc;
  logic [31:0] imm;
  logic [31:0] base_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic        imm_err;
  logic [7:0]  err_count;

  logic        in_valid2;
  logic        in_ready2;
  logic [1:0]  immsrc2;
  logic [31:0] imm2;
  logic [31:0] base2;
  logic        out_valid2;
  logic        out_ready2;
  logic [31:0] instr_out2;
  logic        imm_err2;
  logic [1:0]  err_count2;

  exp_t sb[$];
  exp_t nxt_exp;
  int   total = 0;
  int   bad   = 0;
  int   model_cnt = 0;
  bit   rnd_on = 1'b0;

  always #5 clk = ~clk;

  imm_encoder #(.ERRW(8)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .imm(imm), .base_instr(base_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .imm_err(imm_err), .err_count(err_count)
  );

  imm_encoder #(.ERRW(2)) dut2 (
    .clk(clk), .reset(reset),
    .in_valid(in_valid2), .in_ready(in_ready2),
    .immsrc(immsrc2), .imm(imm2), .base_instr(base2),
    .out_valid(out_valid2), .out_ready(out_ready2),
    .instr_out(instr_out2), .imm_err(imm_err2), .err_count(err_count2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: each format is a list of (instr_hi, instr_lo, imm_lo) segments;
  // legality is a plain signed-range test plus even-ness for branch/jump.
  function automatic exp_t model(input logic [1:0] src, input logic [31:0] v, input logic [31:0] base);
    int hi[4], lo[4], ml[4];
    int n;
    longint sv, lim_lo, lim_hi;
    bit align;
    exp_t e;
    case (src)
      2'd0: begin n = 1; hi = '{31, 0, 0, 0}; lo = '{20, 0, 0, 0}; ml = '{0, 0, 0, 0};
                  lim_lo = -2048; lim_hi = 2047; align = 0; end
      2'd1: begin n = 2; hi = '{31, 11, 0, 0}; lo = '{25, 7, 0, 0}; ml = '{5, 0, 0, 0};
                  lim_lo = -2048; lim_hi = 2047; align = 0; end
      2'd2: begin n = 4; hi = '{31, 30, 11, 7}; lo = '{31, 25, 8, 7}; ml = '{12, 5, 1, 11};
                  lim_lo = -4096; lim_hi = 4094; align = 1; end
      default: begin n = 4; hi = '{31, 30, 20, 19}; lo = '{31, 21, 20, 12}; ml = '{20, 1, 11, 12};
                  lim_lo = -1048576; lim_hi = 1048574; align = 1; end
    endcase
    e.instr = base;
    for (int s = 0; s < n; s++)
      for (int k = lo[s]; k <= hi[s]; k++)
        e.instr[k] = v[ml[s] + k - lo[s]];
    sv = longint'($signed(v));
    e.err = (sv < lim_lo) || (sv > lim_hi) || (align && v[0]);
    return e;
  endfunction

  // Monitor: evaluates handshakes that will complete at the next rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got instr=%h want none at %0t", instr_out, $time);
        end else begin
          check("instr_out", instr_out, sb[0].instr);
          check("imm_err", {31'd0, imm_err}, {31'd0, sb[0].err});
          if (out_ready) begin
            check("err_count", {24'd0, err_count}, model_cnt);
            if (sb[0].err && model_cnt < 255) model_cnt++;
            void'(sb.pop_front());
          end
        end
      end
      if (in_valid && in_ready) sb.push_back(nxt_exp);
    end
  end

  always @(posedge clk) begin
    if (rnd_on) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Presents a beat (called at posedge+1) and returns at posedge+1 of its acceptance edge.
  task automatic send(input logic [1:0] s, input logic [31:0] v, input logic [31:0] b,
                      input logic [31:0] e_instr, input logic e_err);
    bit acc = 1'b0;
    immsrc     = s;
    imm        = v;
    base_instr = b;
    nxt_exp    = '{e_instr, e_err};
    in_valid   = 1'b1;
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 want 1 within 200 cycles");
    end
  endtask

  task automatic send_model(input logic [1:0] s, input logic [31:0] v, input logic [31:0] b);
    exp_t e;
    e = model(s, v, b);
    send(s, v, b, e.instr, e.err);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] r;
    logic [31:0] bnd[12];
    bnd = '{32'd2047, -32'sd2048, 32'd2048, -32'sd2049, 32'd4094, -32'sd4096,
            32'd4096, 32'd4095, 32'd1048574, -32'sd1048576, 32'd1048576, 32'd1048575};
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return bnd[$urandom_range(0, 11)];
      default: return {{11{r[20]}}, r[20:0]};
    endcase
  endfunction

  initial begin
    logic [31:0] bp_imm[4];
    logic [1:0]  bp_src[4];
    logic [31:0] bp_base[4];
    exp_t        e;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    immsrc = 2'b00; imm = 32'd0; base_instr = 32'd0; nxt_exp = '{32'd0, 1'b0};
    in_valid2 = 1'b0; out_ready2 = 1'b1; immsrc2 = 2'b00; imm2 = 32'd0; base2 = 32'h00000093;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_instr_out", instr_out, 32'd0);
    check("rst_imm_err", {31'd0, imm_err}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // I-type with latency check.
    @(posedge clk); #1;
    send(2'b00, 32'hFFFFFFFF, 32'h00000093, 32'hFFF00093, 1'b0);
    in_valid = 1'b0;
    check("lat_cycle1", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    check("lat_cycle2", {31'd0, out_valid}, 32'd1);
    wait_drain();

    // S then B back-to-back, then J pair.
    send(2'b01, 32'd8, 32'h0020A023, 32'h0020A423, 1'b0);
    send(2'b10, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 1'b0);
    send(2'b11, 32'h00000800, 32'h000000EF, 32'h001000EF, 1'b0);
    send(2'b11, 32'd0, 32'h0000006F, 32'h0000006F, 1'b0);
    in_valid = 1'b0;
    wait_drain();

    // Range errors and boundaries.
    send(2'b00, 32'd2048, 32'h00000093, 32'h80000093, 1'b1);
    send(2'b00, 32'd2047, 32'h00000093, 32'h7FF00093, 1'b0);
    send(2'b10, 32'd3, 32'h00000063, 32'h00000163, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    @(negedge clk);
    check("err_count_two", {24'd0, err_count}, 32'd2);
    @(posedge clk); #1;

    // Backpressure: two beats fill the pipe, the third must stall.
    for (int i = 0; i < 4; i++) begin
      bp_src[i]  = 2'($urandom_range(0, 3));
      bp_imm[i]  = rand_imm();
      bp_base[i] = $urandom;
    end
    out_ready = 1'b0;
    send_model(bp_src[0], bp_imm[0], bp_base[0]);
    send_model(bp_src[1], bp_imm[1], bp_base[1]);
    e = model(bp_src[2], bp_imm[2], bp_base[2]);
    immsrc = bp_src[2]; imm = bp_imm[2]; base_instr = bp_base[2]; nxt_exp = e; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_model(bp_src[2], bp_imm[2], bp_base[2]);
    send_model(bp_src[3], bp_imm[3], bp_base[3]);
    in_valid = 1'b0;
    wait_drain();

    // Randomized traffic with random downstream stalls.
    rnd_on = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send_model(2'($urandom_range(0, 3)), rand_imm(), $urandom);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    rnd_on = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();

    // Reset with both stages full.
    out_ready = 1'b0;
    send_model(2'b00, 32'd5000, 32'h00000013);
    send_model(2'b01, 32'd4, 32'h00002023);
    in_valid = 1'b0;
    @(negedge clk); #2;
    reset = 1'b1;
    sb.delete();
    model_cnt = 0;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_err_count", {24'd0, err_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("no_stale_beat", {31'd0, out_valid}, 32'd0);

    // Saturation on the 2-bit counter instance: five error beats.
    @(posedge clk); #1;
    immsrc2 = 2'b00; imm2 = 32'd4096; in_valid2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("sat_in_ready", {31'd0, in_ready2}, 32'd1);
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("sat_err_count", {30'd0, err_count2}, 32'd3);
    check("sat_idle", {31'd0, out_valid2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Elastic 2-stage pipelined immediate packer: the inverse of the immediate sign-extension path in the datapath.
- Takes a 32-bit immediate and an immsrc type and scatters the immediate bits into the instruction-word field positions over a base instruction, producing a complete RV32I instruction word.
- Range-checks and alignment-checks the immediate, and keeps a saturating error counter.
- Used by the instruction-patching/self-test logic and by the bench-side program builder.

Parameters:
- ERRW, 8, width of saturating error counter err_count

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_ready  output  1  encoder can accept input beat
- immsrc  input  2  00 I-type, 01 S-type, 10 B-type, 11 JAL
- imm  input  32  two's-complement immediate value (byte offset for B/J)
- base_instr  input  32  instruction with opcode/rd/rs1/rs2/funct fields; immediate-field bits ignored
- out_valid  output  1  output beat valid
- out_ready  input  1  downstream accepts output beat
- instr_out  output  32  encoded instruction
- imm_err  output  1  immediate out of range or misaligned for this beat (qualified by out_valid)
- err_count  output  ERRW  saturating count of accepted beats with imm_err=1

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, instr_out=0, imm_err=0, err_count=0. in_ready=1 immediately after reset deasserts.
- Reset mid-operation: in-flight beats are discarded. No output beat is produced for them.
- Handshake:
  - Transfer on valid&&ready at the rising edge.
  - out_valid, instr_out and imm_err stay stable while out_valid=1 && out_ready=0.
  - in_valid may drop without a transfer.
- Pipeline:
  - Stage 1 registers {immsrc, imm, base_instr}.
  - Stage 2 registers the encoded {instr, err} and drives the outputs directly (out_valid = s2_valid).
  - Latency: 2 cycles from input acceptance to out_valid when unstalled. Throughput: 1 beat/cycle.
  - s2 loads when !s2_valid || out_ready.
  - s1 advances into s2 under the same condition.
  - in_ready = !s1_valid || !s2_valid || out_ready (combinational).
  - When both stages are full and stalled: in_ready=0, no beat lost or duplicated, order preserved.
- Encoding: instr_out = base_instr with the immediate fields replaced as below; all other bits pass through unchanged.
  - I: [31:20]=imm[11:0].
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0].
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- Range check (signed), imm_err=1 if violated:
  - I/S: -2048..2047.
  - B: -4096..4094 and imm[0]=0.
  - J: -1048576..1048574 and imm[0]=0.
  - The check is that the immediate sign-extended from the field width equals imm. Boundary values (e.g. I 2047, -2048) are legal.
- On error: the instruction is still emitted with the truncated field bits (imm[0] dropped for B/J), with imm_err=1.
- err_count:
  - Increments by 1 on each output transfer (out_valid&&out_ready) with imm_err=1.
  - Saturates at 2^ERRW-1 and does not wrap.
  - Cleared only by reset.

Test Plan:
- I-type: base 0x00000093, immsrc=00, imm=0xFFFFFFFF, out_ready=1 -> instr_out=0xFFF00093 exactly 2 cycles after acceptance, imm_err=0.
- S/B: base 0x0020A023, immsrc=01, imm=8 -> 0x0020A423; then base 0x00000063, immsrc=10, imm=0xFFFFFFFC -> 0xFE000EE3. Both imm_err=0, back-to-back, in order.
- J: base 0x000000EF, immsrc=11, imm=0x800 -> 0x001000EF; imm=0 with base 0x0000006F -> 0x0000006F.
- Errors:
  - I imm=2048 -> imm_err=1, instr_out=0x80000093 (base 0x00000093).
  - I imm=2047 -> imm_err=0.
  - B imm=3 -> imm_err=1.
  - err_count=2 after both error beats are taken.
- Backpressure: stream 4 beats with out_ready held 0 -> in_ready drops after 2 accepted, outputs held stable. Release out_ready -> 4 beats out in order, none lost or duplicated.
- Reset/saturation:
  - Assert reset with both stages full -> out_valid=0 and err_count=0 immediately (asynchronous), no stale beat after release.
  - With ERRW=2, 5 error beats -> err_count=3.
